test_circuit_bist: RTL and testbench

- Self-test driver and response compactor for the combinational cone block under LogicConeMiner test.
- Generates exhaustive input patterns for the block's inputs (a,b,c,d) and compresses its outputs (y1,y2,y3) into a MISR signature.
- Compares the final signature against a golden value and reports pass/fail.
- Sits on the opposite side of the circuit's I/O: drives what the circuit consumes, consumes what it drives.

---
 rtl/test_circuit_bist.sv | 113 +++++++++++
 tb/tb_test_circuit_bist.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/test_circuit_bist.sv
// Self-test driver for a small combinational cone: sweeps every input pattern,
// folds the responses into a MISR and compares the final signature to a golden value.
module test_circuit_bist #(
  parameter int               PAT_W    = 4,
  parameter int               RESP_W   = 3,
  parameter int               NUM_PAT  = 16,
  parameter int               SIG_W    = 16,
  parameter logic [SIG_W-1:0] SIG_POLY = 16'h1021,
  parameter logic [SIG_W-1:0] GOLDEN   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [RESP_W-1:0] resp_in,
  output logic [PAT_W-1:0]  pat_out,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [SIG_W-1:0]  signature
);

  localparam int CNT_W = $clog2(NUM_PAT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One MISR clock: shift left, fold the dropped MSB back through the polynomial, inject the response.
  function automatic logic [SIG_W-1:0] misr_step(input logic [SIG_W-1:0] sig,
                                                 input logic [RESP_W-1:0] resp);
    logic [SIG_W-1:0] fb;
    fb = sig[SIG_W-1] ? SIG_POLY : {SIG_W{1'b0}};
    return {sig[SIG_W-2:0], 1'b0} ^ fb ^ SIG_W'(resp);
  endfunction

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [PAT_W-1:0] pat_q;
  logic [PAT_W-1:0] pat_d;
  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_d;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;

  // Next-state values used while a run is in progress.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    pat_d = PAT_W'(cnt_d);
    sig_d = misr_step(sig_q, resp_in);
  end

  // Run sequencer with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= {CNT_W{1'b0}};
      pat_q   <= {PAT_W{1'b0}};
      sig_q   <= {SIG_W{1'b0}};
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RUN;
            cnt_q   <= {CNT_W{1'b0}};
            pat_q   <= {PAT_W{1'b0}};
            sig_q   <= {SIG_W{1'b0}};
            pass_q  <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        RUN: begin
          sig_q <= sig_d;
          cnt_q <= cnt_d;
          // The edge that captures the last response also closes the run.
          if (cnt_q == LAST_CNT) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pat_q   <= {PAT_W{1'b0}};
          end else begin
            pat_q <= pat_d;
          end
        end
        DONE: begin
          state_q <= IDLE;
          done_q  <= 1'b0;
          pass_q  <= (sig_q == GOLDEN);
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          pat_q   <= {PAT_W{1'b0}};
        end
      endcase
    end
  end

  assign pat_out   = pat_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_test_circuit_bist.sv
// Bench for test_circuit_bist: a cycle-level reference of the run sequence feeds a
// scoreboard queue, and a vector table fixes the expected signature of each sweep.
module tb_test_circuit_bist;
  localparam int NP = 16;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  resp_in;
  logic [3:0]  pat_out;
  logic        busy;
  logic        done;
  logic        pass;
  logic [15:0] signature;

  test_circuit_bist dut (
    .clk(clk), .rst(rst), .start(start), .resp_in(resp_in),
    .pat_out(pat_out), .busy(busy), .done(done), .pass(pass), .signature(signature)
  );

  always #5 clk = ~clk;

  // Stand-in for the cone: one chosen pattern produces a non-zero response.
  logic [3:0] hot_pat;
  logic [2:0] hot_val;
  always_comb resp_in = (busy && pat_out == hot_pat) ? hot_val : 3'b000;

  typedef struct {
    int         hot_pat;
    logic [2:0] hot_val;
    int         restart_at;
    logic [15:0] exp_sig;
    logic       exp_pass;
  } vec_t;

  typedef struct {
    logic [3:0]  pat;
    logic        busy;
    logic        done;
    logic        chk_sig;
    logic [15:0] sig;
    logic        pass;
  } exp_t;

  vec_t  tbl[6];
  exp_t  sb_q[$];
  int    n_cmp, n_err, cyc;
  int    ph;
  logic        sig_k;
  logic [15:0] sig_m;
  logic        pass_m;
  logic [15:0] cur_sig;
  logic        cur_pass;
  int    busy_seen, done_seen;
  int    done_cycs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
    end
  endtask

  // Drive one cycle, predict the post-edge outputs, then compare them.
  task automatic cycle(input logic r, input logic s);
    exp_t e;
    rst = r;
    start = s;
    if (r) begin
      ph = -1; sig_k = 1'b1; sig_m = 16'h0000; pass_m = 1'b0;
    end else if (ph == -1) begin
      if (s) begin
        ph = 0; sig_k = 1'b1; sig_m = 16'h0000; pass_m = 1'b0;
      end
    end else if (ph < NP - 1) begin
      ph = ph + 1; sig_k = 1'b0;
    end else if (ph == NP - 1) begin
      ph = NP; sig_k = 1'b1; sig_m = cur_sig;
    end else begin
      ph = -1; pass_m = cur_pass;
    end
    e.busy    = (ph >= 0 && ph < NP);
    e.pat     = e.busy ? 4'(ph) : 4'h0;
    e.done    = (ph == NP);
    e.chk_sig = sig_k;
    e.sig     = sig_m;
    e.pass    = pass_m;
    sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc++;
    e = sb_q.pop_front();
    chk("pat_out", 32'(pat_out), 32'(e.pat));
    chk("busy", 32'(busy), 32'(e.busy));
    chk("done", 32'(done), 32'(e.done));
    chk("pass", 32'(pass), 32'(e.pass));
    if (e.chk_sig) chk("signature", 32'(signature), 32'(e.sig));
    if (busy) busy_seen++;
    if (done) begin
      done_seen++;
      done_cycs.push_back(cyc);
    end
  endtask

  task automatic run_vec(input int i);
    hot_pat   = 4'(tbl[i].hot_pat);
    hot_val   = tbl[i].hot_val;
    cur_sig   = tbl[i].exp_sig;
    cur_pass  = tbl[i].exp_pass;
    busy_seen = 0;
    done_seen = 0;
    cycle(1'b0, 1'b1);
    for (int n = 0; n < 40 && ph != -1; n++) cycle(1'b0, ph == tbl[i].restart_at);
    chk("busy_len", 32'(busy_seen), 32'(NP));
    chk("done_count", 32'(done_seen), 32'd1);
    cycle(1'b0, 1'b0);
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; start = 1'b0;
    hot_pat = 4'h0; hot_val = 3'b000;
    n_cmp = 0; n_err = 0; cyc = 0; ph = -1;
    sig_k = 1'b1; sig_m = 16'h0000; pass_m = 1'b0;
    cur_sig = 16'h0000; cur_pass = 1'b1;

    tbl[0] = '{0,  3'b000, -1, 16'h0000, 1'b1};  // clean sweep
    tbl[1] = '{0,  3'b001, -1, 16'h8000, 1'b0};  // single bit walks to MSB
    tbl[2] = '{0,  3'b100, -1, 16'h2042, 1'b0};  // overflow through polynomial
    tbl[3] = '{15, 3'b111, -1, 16'h0007, 1'b0};  // last pattern response
    tbl[4] = '{0,  3'b000,  5, 16'h0000, 1'b1};  // start re-pulsed mid-run
    tbl[5] = '{2,  3'b011, -1, 16'h6000, 1'b0};  // mid-run response

    repeat (2) cycle(1'b1, 1'b0);
    repeat (4) cycle(1'b0, 1'b0);

    for (int i = 0; i < 6; i++) run_vec(i);

    // Abort at pattern 9: no done pulse, state cleared, then a full sweep.
    hot_pat = 4'h2; hot_val = 3'b111;
    done_seen = 0;
    cycle(1'b0, 1'b1);
    for (int n = 0; n < 20 && ph != 9; n++) cycle(1'b0, 1'b0);
    chk("abort_pat", 32'(pat_out), 32'd9);
    cycle(1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b0);
    chk("abort_done", 32'(done_seen), 32'd0);
    run_vec(0);

    // Start held high: done pulses spaced by the back-to-back period.
    hot_pat = 4'h0; hot_val = 3'b000; cur_sig = 16'h0000; cur_pass = 1'b1;
    done_seen = 0;
    done_cycs.delete();
    repeat (3 * (NP + 2)) cycle(1'b0, 1'b1);
    repeat (2) cycle(1'b0, 1'b0);
    chk("b2b_done_count", 32'(done_seen), 32'd3);
    for (int k = 1; k < done_cycs.size(); k++)
      chk("b2b_gap", 32'(done_cycs[k] - done_cycs[k-1]), 32'(NP + 2));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
